// File: rtl/foc_dlmon_pkg.sv
// Shared types and helpers for the FOC deadlock monitor.
package foc_dlmon_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        DEAD  = 2'd2
    } state_t;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int w);
        logic [32:0] limit;
        limit = (33'd1 << w) - 33'd1;
        return (value == limit[31:0]) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/foc_dlmon_cond.sv
// Reduces AXIS and sub-instance flags into one stall condition; an idle instance never counts.
module foc_dlmon_cond #(
    parameter int NUM_AXIS = 3,
    parameter int NUM_INST = 1
) (
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic [NUM_INST-1:0] inst_eff,
    output logic                cond
);

    assign inst_eff = inst_block_sigs & ~inst_idle_sigs;
    assign cond     = (|axis_block_sigs) | (|inst_eff);

endmodule

// File: rtl/foc_deadlock_monitor_v2.sv
// Deadlock monitor: registered block flag, persistence filter and sticky deadlock latch.
// Define FOC_DLMON_STATS_EN to add the max_stall statistics output.
module foc_deadlock_monitor_v2
    import foc_dlmon_pkg::*;
#(
    parameter int NUM_AXIS = 3,
    parameter int NUM_INST = 1,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_AXIS-1:0]          axis_block_sigs,
    input  logic [NUM_INST-1:0]          inst_idle_sigs,
    input  logic [NUM_INST-1:0]          inst_block_sigs,
    input  logic                         enable,
    input  logic [CNT_W-1:0]             threshold,
    input  logic                         clear,
    output logic                         block,
    output logic                         deadlock,
    output logic [NUM_AXIS+NUM_INST-1:0] block_src,
    output logic [CNT_W-1:0]             stall_count
`ifdef FOC_DLMON_STATS_EN
    ,
    output logic [CNT_W-1:0]             max_stall
`endif
);

    localparam logic [CNT_W:0] ONE_W = 1;

    state_t                        state;
    logic                          cond;
    logic [NUM_INST-1:0]           inst_eff;
    logic [NUM_AXIS+NUM_INST-1:0]  snapshot;
    logic [CNT_W-1:0]              thr_eff;
    logic [CNT_W-1:0]              cnt_inc;
    logic [CNT_W:0]                cnt_plus;
    logic                          reach;

    foc_dlmon_cond #(
        .NUM_AXIS (NUM_AXIS),
        .NUM_INST (NUM_INST)
    ) u_cond (
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .inst_eff        (inst_eff),
        .cond            (cond)
    );

    assign snapshot = {inst_eff, axis_block_sigs};
    assign thr_eff  = (threshold == '0) ? CNT_W'(1) : threshold;
    assign cnt_inc  = CNT_W'(sat_inc(32'(stall_count), CNT_W));
    // Compare one bit wider so the threshold test is unaffected by counter saturation.
    assign cnt_plus = {1'b0, stall_count} + ONE_W;
    assign reach    = cnt_plus >= {1'b0, thr_eff};

    // NOTE: reset is synchronous, so it is just the first branch of the clocked block;
    // every state register uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            block       <= 1'b0;
            deadlock    <= 1'b0;
            block_src   <= '0;
            stall_count <= '0;
        end else begin
            block <= cond;
            case (state)
                IDLE: begin
                    if (enable && cond) begin
                        stall_count <= CNT_W'(1);
                        if (thr_eff == CNT_W'(1)) begin
                            state     <= DEAD;
                            deadlock  <= 1'b1;
                            block_src <= snapshot;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!cond || !enable) begin
                        stall_count <= '0;
                        state       <= IDLE;
                    end else begin
                        stall_count <= cnt_inc;
                        if (reach) begin
                            state     <= DEAD;
                            deadlock  <= 1'b1;
                            block_src <= snapshot;
                        end
                    end
                end
                DEAD: begin
                    // Clear wins over a live stall; the stall re-arms from IDLE next cycle.
                    if (clear) begin
                        stall_count <= '0;
                        deadlock    <= 1'b0;
                        state       <= IDLE;
                    end else if (cond) begin
                        stall_count <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FOC_DLMON_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            max_stall <= '0;
        end else if (stall_count > max_stall) begin
            max_stall <= stall_count;
        end
    end
`endif

endmodule
